wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares NUM_PORT writeback/bypass ports between NUM_REQ functional-unit result requesters.
//  Picks up to NUM_PORT valid requesters per cycle using a round-robin order.
//  Drives registered (vld, iprIdx, data) triples into the regfile write ports and the bypass select network.
//  Guarantees at most one port carries a given physical register index per cycle.
// PARAMETERS
//  NUM_REQ    6   number of result requesters (FU writeback sources), >=2
//  NUM_PORT   4   number of writeback/bypass ports, 1..NUM_REQ
// PORTS
//  clk          in   1                 core clock
//  rst          in   1                 synchronous reset, active-high
//  i_req_vld    in   NUM_REQ           requester i holds a result
//  o_req_rdy    out  NUM_REQ           requester i granted this cycle (combinational)
//  i_req_idx    in   iprIdx_t[NUM_REQ] destination physical register
//  i_req_data   in   XLEN x NUM_REQ    result data
//  o_wb_vld     out  NUM_PORT          port p carries a valid writeback
//  o_wb_idx     out  iprIdx_t[NUM_PORT]  port p physical register index
//  o_wb_data    out  XLEN x NUM_PORT   port p data
//  o_stall_cnt  out  32                cycles with >=1 valid requester not granted
// BEHAVIOUR
//  - Handshake: fire[i] = i_req_vld[i] & o_req_rdy[i].
//    - A requester holds vld/idx/data stable until fire.
//    - o_req_rdy[i] never depends on i_req_vld[i] being low.
//  - Grant: scan requesters starting at rr_ptr, incrementing mod NUM_REQ.
//    - The first min(NUM_PORT, popcount(vld)) valid requesters are granted.
//    - Grant k (scan order) is assigned to port k (lowest port first).
//  - rr_ptr (clog2(NUM_REQ) bits, reset 0):
//    - On any grant: (index of last granted + 1) mod NUM_REQ.
//    - No grant: unchanged.
//    - Wrap from NUM_REQ-1 goes to 0.
//  - Latency: 1 cycle. Requester fire in cycle T -> o_wb_* valid in cycle T+1. Output registers update every cycle.
//  - Unused ports in a cycle: o_wb_vld=0; idx/data are don't-care and are driven 0.
//  - Fairness: a continuously valid requester is granted within ceil(NUM_REQ/NUM_PORT) cycles.
//  - popcount(vld) <= NUM_PORT: all valid requesters granted; o_stall_cnt does not increment.
//  - Duplicate idx: two valid requesters with equal i_req_idx in one cycle is illegal.
//    - An assertion fires, gated off while rst.
//    - Arbitration still proceeds by scan order.
//  - Reset (also mid-operation):
//    - o_wb_vld=0, o_wb_idx=0, o_wb_data=0, rr_ptr=0, o_req_rdy=0, o_stall_cnt=0.
//    - Requests pending during reset are not granted and are not lost; requesters keep them asserted.
// CONFIGURATION
//  WB_ARB_STALL_CNT_EN
//    defined:   o_stall_cnt increments by 1 each cycle with a valid, ungranted requester; saturates at 32'hFFFF_FFFF.
//    undefined: counter logic is omitted; o_stall_cnt is tied to 0.
// STRUCTURE
//  - Shared package (core_define.svh) holds:
//    - iprIdx_t.
//    - typedef wbReq_t struct {iprIdx_t idx; logic[XLEN-1:0] data;}.
//    - Defaults NUM_WB_REQ / NUM_WB_PORT.
//  - Sub-module rr_multi_grant #(N, M): combinational.
//    - Inputs: req[N], ptr.
//    - Outputs: gnt[N], port-select index per port with valid, last_gnt index.
//  - Top: rr_multi_grant + output registers + rr_ptr register + optional stall counter.
// TESTING
//  - Reset: assert rst 3 cycles with all vld=1 -> o_wb_vld=0, o_req_rdy=0; first cycle after rst, requesters 0..3 granted.
//  - Light load: vld=6'b000101 (idx 10, 20) -> rdy=6'b000101; next cycle port0={10,d0}, port1={20,d2}, ports2-3 vld=0; stall_cnt unchanged.
//  - Oversubscribed, rr_ptr=0, all 6 valid, held:
//    - Cycle 0 grants 0-3, rr_ptr=4.
//    - Cycle 1 grants 4,5,0,1 (ports 0-3), rr_ptr=2.
//    - stall_cnt +2 (macro on).
//  - Wrap: rr_ptr=5, vld=6'b100011 -> requester 5 on port0, 0 on port1, 1 on port2; rr_ptr becomes 2.
//  - Reset mid-flight: rst during an oversubscribed cycle -> next-cycle outputs all 0, rr_ptr=0; held requests granted after rst drops.
//  - Duplicate: requesters 1 and 3 both idx 7 -> assertion fires; with rst=1 no assertion.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter_pkg
// Shared definitions for the writeback port arbiter slice:
//   XLEN          result data width
//   IPR_IDX_W     physical register index width
//   iprIdx_t      physical register index type
//   wbReq_t       one writeback payload (index + data)
//   NUM_WB_REQ    default number of result requesters
//   NUM_WB_PORT   default number of writeback/bypass ports
// ---------------------------------------------------------------------------
package wb_port_arbiter_pkg;

    localparam int XLEN        = 64;
    localparam int IPR_IDX_W   = 7;
    localparam int NUM_WB_REQ  = 6;
    localparam int NUM_WB_PORT = 4;

    typedef logic [IPR_IDX_W-1:0] iprIdx_t;

    typedef struct packed {
        iprIdx_t          idx;
        logic [XLEN-1:0]  data;
    } wbReq_t;

endpackage

// File: rtl/wb_port_arbiter_rr_multi_grant.sv
// ---------------------------------------------------------------------------
// rr_multi_grant
// Combinational round-robin picker granting up to M of N requesters.
// Requesters are scanned starting at ptr (wrapping mod N); the k-th valid
// requester found is granted and steered to port k.
// Ports:
//   req       in   N        request vector
//   ptr       in   PW       scan start index
//   gnt       out  N        grant vector
//   port_sel  out  M x PW   requester index driving each port
//   port_vld  out  M        port carries a grant
//   last_gnt  out  PW       index of the last requester granted in scan order
//   any_gnt   out  1        at least one grant this cycle
// ---------------------------------------------------------------------------
module rr_multi_grant #(
    parameter int N  = 6,
    parameter int M  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]         req,
    input  logic [PW-1:0]        ptr,
    output logic [N-1:0]         gnt,
    output logic [M-1:0][PW-1:0] port_sel,
    output logic [M-1:0]         port_vld,
    output logic [PW-1:0]        last_gnt,
    output logic                 any_gnt
);

    localparam int CW = (M > 1) ? $clog2(M) : 1;

    int              cnt;
    int              sum;
    logic [PW-1:0]   cur;

    always_comb begin
        gnt      = '0;
        port_sel = '0;
        port_vld = '0;
        last_gnt = '0;
        any_gnt  = 1'b0;
        cnt      = 0;
        sum      = 0;
        cur      = '0;
        for (int k = 0; k < N; k++) begin
            sum = int'(ptr) + k;
            // ptr < N and k < N, so one conditional subtract is a full mod N
            cur = (sum >= N) ? PW'(sum - N) : PW'(sum);
            if (req[cur] && (cnt < M)) begin
                gnt[cur]               = 1'b1;
                port_sel[CW'(cnt)]     = cur;
                port_vld[CW'(cnt)]     = 1'b1;
                last_gnt               = cur;
                any_gnt                = 1'b1;
                cnt                    = cnt + 1;
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
// Shares NUM_PORT writeback/bypass ports between NUM_REQ functional-unit
// result requesters using a round-robin scan. Winners are registered and
// presented on the ports one cycle after their handshake.
// Optional feature macro: WB_ARB_STALL_CNT_EN enables a saturating counter
// of cycles in which some valid requester was not granted; without it
// o_stall_cnt is tied to 0.
// Ports:
//   clk          in   1                    core clock
//   rst          in   1                    synchronous reset, active-high
//   i_req_vld    in   NUM_REQ              requester holds a result
//   o_req_rdy    out  NUM_REQ              requester granted (combinational)
//   i_req_idx    in   NUM_REQ x IPR_IDX_W  destination physical register
//   i_req_data   in   NUM_REQ x XLEN       result data
//   o_wb_vld     out  NUM_PORT             port carries a valid writeback
//   o_wb_idx     out  NUM_PORT x IPR_IDX_W port physical register index
//   o_wb_data    out  NUM_PORT x XLEN      port data
//   o_stall_cnt  out  32                   stalled-cycle count
// ---------------------------------------------------------------------------
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = NUM_WB_REQ,
    parameter int NUM_PORT = NUM_WB_PORT
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  i_req_vld,
    output logic [NUM_REQ-1:0]                  o_req_rdy,
    input  logic [NUM_REQ-1:0][IPR_IDX_W-1:0]   i_req_idx,
    input  logic [NUM_REQ-1:0][XLEN-1:0]        i_req_data,
    output logic [NUM_PORT-1:0]                 o_wb_vld,
    output logic [NUM_PORT-1:0][IPR_IDX_W-1:0]  o_wb_idx,
    output logic [NUM_PORT-1:0][XLEN-1:0]       o_wb_data,
    output logic [31:0]                         o_stall_cnt
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]                rr_ptr;
    logic [PTR_W-1:0]                rr_ptr_nxt;
    logic [NUM_REQ-1:0]              gnt;
    logic [NUM_PORT-1:0][PTR_W-1:0]  port_sel;
    logic [NUM_PORT-1:0]             port_vld;
    logic [PTR_W-1:0]                last_gnt;
    logic                            any_gnt;

    logic [NUM_PORT-1:0]             wb_vld_q;
    wbReq_t [NUM_PORT-1:0]           wb_q;

    rr_multi_grant #(
        .N  (NUM_REQ),
        .M  (NUM_PORT),
        .PW (PTR_W)
    ) u_pick (
        .req      (i_req_vld),
        .ptr      (rr_ptr),
        .gnt      (gnt),
        .port_sel (port_sel),
        .port_vld (port_vld),
        .last_gnt (last_gnt),
        .any_gnt  (any_gnt)
    );

    // Nothing may fire while reset is held, so held requests survive reset.
    assign o_req_rdy = rst ? '0 : gnt;

    assign rr_ptr_nxt = (last_gnt == PTR_W'(NUM_REQ - 1)) ? '0 : last_gnt + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            wb_vld_q <= '0;
            wb_q     <= '0;
        end else begin
            if (any_gnt) begin
                rr_ptr <= rr_ptr_nxt;
            end
            wb_vld_q <= port_vld;
            // Unused ports are driven to zero rather than holding stale data.
            for (int p = 0; p < NUM_PORT; p++) begin
                if (port_vld[p]) begin
                    wb_q[p].idx  <= i_req_idx[port_sel[p]];
                    wb_q[p].data <= i_req_data[port_sel[p]];
                end else begin
                    wb_q[p] <= '0;
                end
            end
        end
    end

    always_comb begin
        o_wb_vld  = wb_vld_q;
        o_wb_idx  = '0;
        o_wb_data = '0;
        for (int p = 0; p < NUM_PORT; p++) begin
            o_wb_idx[p]  = wb_q[p].idx;
            o_wb_data[p] = wb_q[p].data;
        end
    end

`ifdef WB_ARB_STALL_CNT_EN
    logic        stall_now;
    logic [31:0] stall_q;

    assign stall_now = |(i_req_vld & ~gnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (stall_now && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign o_stall_cnt = stall_q;
`else
    assign o_stall_cnt = '0;
`endif

`ifndef SYNTHESIS
    // Two valid requesters targeting the same physical register is illegal.
    logic dup_idx;

    always_comb begin
        dup_idx = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = i + 1; j < NUM_REQ; j++) begin
                if (i_req_vld[i] && i_req_vld[j] && (i_req_idx[i] == i_req_idx[j])) begin
                    dup_idx = 1'b1;
                end
            end
        end
    end

    a_no_dup_idx: assert property (@(posedge clk) disable iff (rst) !dup_idx);
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter
// Directed-vector bench for wb_port_arbiter. Each vector drives one cycle of
// requests and carries the hand-derived grant vector and port assignment.
// The driver checks the combinational ready and queues the registered
// response; a monitor pops and compares it one cycle later.
// ---------------------------------------------------------------------------
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int NR = 6;
    localparam int NP = 4;

    logic                              clk = 1'b0;
    logic                              rst;
    logic [NR-1:0]                     i_req_vld;
    logic [NR-1:0]                     o_req_rdy;
    logic [NR-1:0][IPR_IDX_W-1:0]      i_req_idx;
    logic [NR-1:0][XLEN-1:0]           i_req_data;
    logic [NP-1:0]                     o_wb_vld;
    logic [NP-1:0][IPR_IDX_W-1:0]      o_wb_idx;
    logic [NP-1:0][XLEN-1:0]           o_wb_data;
    logic [31:0]                       o_stall_cnt;

    wb_port_arbiter #(.NUM_REQ(NR), .NUM_PORT(NP)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_vld   (i_req_vld),
        .o_req_rdy   (o_req_rdy),
        .i_req_idx   (i_req_idx),
        .i_req_data  (i_req_data),
        .o_wb_vld    (o_wb_vld),
        .o_wb_idx    (o_wb_idx),
        .o_wb_data   (o_wb_data),
        .o_stall_cnt (o_stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [NR-1:0] vld;
        logic [NR-1:0] rdy;
        int            port [NP];
        logic          inc;
        logic          dup;
    } vec_t;

    typedef struct {
        logic [NP-1:0]                 vld;
        logic [NP-1:0][IPR_IDX_W-1:0]  idx;
        logic [NP-1:0][XLEN-1:0]       data;
        logic [31:0]                   stall;
    } exp_t;

    vec_t        vecs [$];
    exp_t        exp_q [$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] stall_model = '0;
    int          idx_tab [NR] = '{10, 15, 20, 30, 40, 50};

    function automatic logic [XLEN-1:0] data_of(input int r);
        return 64'hDA7A_0000_0000_0000 + 64'(r * 17 + 1);
    endfunction

    task automatic addVec(input logic r, input logic [NR-1:0] v, input logic [NR-1:0] g,
                          input int p0, input int p1, input int p2, input int p3,
                          input logic inc, input logic dup);
        vec_t t;
        t.rst = r; t.vld = v; t.rdy = g;
        t.port[0] = p0; t.port[1] = p1; t.port[2] = p2; t.port[3] = p3;
        t.inc = inc; t.dup = dup;
        vecs.push_back(t);
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        @(negedge clk);
        rst       = v.rst;
        i_req_vld = v.vld;
        for (int r = 0; r < NR; r++) begin
            i_req_idx[r]  = IPR_IDX_W'(idx_tab[r]);
            i_req_data[r] = data_of(r);
        end
        if (v.dup) begin
            i_req_idx[1] = 7'd7;
            i_req_idx[3] = 7'd7;
        end
        #1;
        checks++;
        if (o_req_rdy !== v.rdy) begin
            errors++;
            $display("[TB] FAIL rdy: got %b expected %b", o_req_rdy, v.rdy);
        end
        if (v.rst) begin
            stall_model = '0;
        end else if (v.inc) begin
`ifdef WB_ARB_STALL_CNT_EN
            stall_model = stall_model + 32'd1;
`endif
        end
        e.vld = '0; e.idx = '0; e.data = '0; e.stall = stall_model;
        if (!v.rst) begin
            for (int p = 0; p < NP; p++) begin
                if (v.port[p] >= 0) begin
                    e.vld[p]  = 1'b1;
                    e.idx[p]  = IPR_IDX_W'(idx_tab[v.port[p]]);
                    e.data[p] = data_of(v.port[p]);
                end
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (o_wb_vld !== e.vld) begin
            errors++;
            $display("[TB] FAIL wb_vld: got %b expected %b", o_wb_vld, e.vld);
        end
        for (int p = 0; p < NP; p++) begin
            checks++;
            if (o_wb_idx[p] !== e.idx[p]) begin
                errors++;
                $display("[TB] FAIL wb_idx[%0d]: got %0d expected %0d", p, o_wb_idx[p], e.idx[p]);
            end
            checks++;
            if (o_wb_data[p] !== e.data[p]) begin
                errors++;
                $display("[TB] FAIL wb_data[%0d]: got %h expected %h", p, o_wb_data[p], e.data[p]);
            end
        end
        checks++;
        if (o_stall_cnt !== e.stall) begin
            errors++;
            $display("[TB] FAIL stall_cnt: got %0d expected %0d", o_stall_cnt, e.stall);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                checkOutput(exp_q.pop_front());
            end
        end
    end

    initial begin
        rst        = 1'b1;
        i_req_vld  = '0;
        i_req_idx  = '0;
        i_req_data = '0;

        // reset held three cycles with every requester asking
        addVec(1, 6'b111111, 6'b000000, -1, -1, -1, -1, 0, 0);
        addVec(1, 6'b111111, 6'b000000, -1, -1, -1, -1, 0, 0);
        addVec(1, 6'b111111, 6'b000000, -1, -1, -1, -1, 0, 0);
        // oversubscribed from ptr 0: 0-3, then 4,5,0,1 (ptr -> 2)
        addVec(0, 6'b111111, 6'b001111,  0,  1,  2,  3, 1, 0);
        addVec(0, 6'b111111, 6'b110011,  4,  5,  0,  1, 1, 0);
        // reset mid-flight, then held requests granted from ptr 0
        addVec(1, 6'b111111, 6'b000000, -1, -1, -1, -1, 0, 0);
        addVec(0, 6'b111111, 6'b001111,  0,  1,  2,  3, 1, 0);
        // single grant moves ptr to 5, then wrap case 5,0,1 (ptr -> 2)
        addVec(0, 6'b010000, 6'b010000,  4, -1, -1, -1, 0, 0);
        addVec(0, 6'b100011, 6'b100011,  5,  0,  1, -1, 0, 0);
        // ptr 2 confirmed: 2,3,4,5 (ptr -> 0)
        addVec(0, 6'b111100, 6'b111100,  2,  3,  4,  5, 0, 0);
        // idle leaves ptr at 0
        addVec(0, 6'b000000, 6'b000000, -1, -1, -1, -1, 0, 0);
        // light load: idx 10 and 20 on ports 0,1 (ptr -> 3)
        addVec(0, 6'b000101, 6'b000101,  0,  2, -1, -1, 0, 0);
        // from ptr 3: 5,1,2 (ptr -> 3)
        addVec(0, 6'b100110, 6'b100110,  5,  1,  2, -1, 0, 0);
        // from ptr 3, all valid: 3,4,5,0 (ptr -> 1)
        addVec(0, 6'b111111, 6'b111001,  3,  4,  5,  0, 1, 0);
        addVec(0, 6'b000010, 6'b000010,  1, -1, -1, -1, 0, 0);
        // duplicate index while in reset: no grants, no assertion
        addVec(1, 6'b001010, 6'b000000, -1, -1, -1, -1, 0, 1);
        addVec(0, 6'b000000, 6'b000000, -1, -1, -1, -1, 0, 0);
        addVec(0, 6'b001010, 6'b001010,  1,  3, -1, -1, 0, 0);
        addVec(0, 6'b000000, 6'b000000, -1, -1, -1, -1, 0, 0);

        foreach (vecs[n]) begin
            applyStimulus(vecs[n]);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d responses left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
